seq_detect_param: RTL and testbench

//   Parametrised serial sequence detector; successor to the fixed 4-bit detector.
//   - Samples one bit per qualified clock and compares the last WIDTH bits with a

---
 rtl/seq_detect_param.sv | 82 ++++++++
 tb/tb_seq_detect_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial sequence detector: compares the last WIDTH accepted bits with a loadable pattern.
// Defining SEQ_DETECT_MASK_EN adds pat_mask_in and per-position don't-care masking.
module seq_detect_param #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1101,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [WIDTH-1:0] pat_mask_in,
`endif
  output logic             flag,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_ARM  = FW'(WIDTH - 1);

  // Only the WIDTH-1 newest bits are kept; the incoming din completes the window.
  logic [WIDTH-2:0] hist;
  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] win;
  logic             accept;
  logic             hit;
`ifdef SEQ_DETECT_MASK_EN
  logic [WIDTH-1:0] mask;
`endif

  // din is consumed on an edge where din_valid is high and no pattern load is in
  // progress; there is no back-pressure, so every such bit is taken.
  always_comb begin
    accept = din_valid && !pat_load;
    win    = {hist, din};
`ifdef SEQ_DETECT_MASK_EN
    hit    = accept && (fill >= FILL_ARM) && (((win ^ pat) & ~mask) == '0);
`else
    hit    = accept && (fill >= FILL_ARM) && (win == pat);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= PATTERN;
      flag      <= 1'b0;
      match_cnt <= '0;
`ifdef SEQ_DETECT_MASK_EN
      mask      <= '0;
`endif
    end else if (pat_load) begin
      pat       <= pat_in;
      fill      <= '0;
      flag      <= 1'b0;
      match_cnt <= '0;
`ifdef SEQ_DETECT_MASK_EN
      mask      <= pat_mask_in;
`endif
    end else begin
      flag <= hit;
      if (din_valid) begin
        hist <= win[WIDTH-2:0];
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        if (hit && !overlap)
          fill <= '0;
        else if (fill != FILL_FULL)
          fill <= fill + FW'(1);
      end
      if (hit && (match_cnt != '1))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboarded bench for seq_detect_param: directed bit strings with hand-computed
// flag/count strings; a second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid;
  logic       din;
  logic       overlap;
  logic       pat_load;
  logic       pat_load2;
  logic [3:0] pat_in;
  logic [3:0] pat_mask_in;
  logic [3:0] pat_mask_zero;
  logic       flag;
  logic [7:0] match_cnt;
  logic       flag2;
  logic [1:0] match_cnt2;

  logic [8:0] exp_q[$];
  string      name_q[$];
  logic [2:0] exp2_q[$];
  string      name2_q[$];
  int         n_pass;
  int         n_total;
  bit         chk1;
  bit         chk2;

  seq_detect_param dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECT_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .flag(flag), .match_cnt(match_cnt)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .overlap(overlap), .pat_load(pat_load2), .pat_in(pat_in),
`ifdef SEQ_DETECT_MASK_EN
    .pat_mask_in(pat_mask_zero),
`endif
    .flag(flag2), .match_cnt(match_cnt2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitors: outputs settle after the rising edge and are checked on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_total++;
      if ({flag, match_cnt} === e) n_pass++;
      else $display("FAIL %s: got flag=%b cnt=%0d, expected flag=%b cnt=%0d",
                    nm, flag, match_cnt, e[8], e[7:0]);
    end
  end

  always @(negedge clk) begin
    if (exp2_q.size() > 0) begin
      logic [2:0] e;
      string      nm;
      e  = exp2_q.pop_front();
      nm = name2_q.pop_front();
      n_total++;
      if ({flag2, match_cnt2} === e) n_pass++;
      else $display("FAIL %s: got flag=%b cnt=%0d, expected flag=%b cnt=%0d",
                    nm, flag2, match_cnt2, e[2], e[1:0]);
    end
  end

  // driver tasks: inputs are set before the edge, expectations queued at the edge
  task automatic tick(input string name, input logic f, input logic [7:0] c);
    @(posedge clk);
    if (chk1) begin
      exp_q.push_back({f, c});
      name_q.push_back(name);
    end
    if (chk2) begin
      exp2_q.push_back({f, c[1:0]});
      name2_q.push_back(name);
    end
    #1;
  endtask

  task automatic do_reset(input string name);
    rst_n     = 1'b0;
    din_valid = 1'b1;
    din       = 1'b1;
    pat_load  = 1'b0;
    tick(name, 1'b0, 8'd0);
    rst_n     = 1'b1;
    din_valid = 1'b0;
  endtask

  // bits: '0'/'1' = valid bit, '.' = invalid cycle with din toggling
  task automatic run_vec(input string name, input string bits, input string flags,
                         input string cnts);
    for (int i = 0; i < bits.len(); i++) begin
      byte b;
      b = bits.getc(i);
      if (b == ".") begin
        din_valid = 1'b0;
        din       = ~din;
      end else begin
        din_valid = 1'b1;
        din       = (b == "1");
      end
      tick($sformatf("%s[%0d]", name, i), flags.getc(i) == "1",
           8'(cnts.getc(i) - 8'd48));
    end
    din_valid = 1'b0;
  endtask

  task automatic load(input string name, input logic [3:0] p, input logic [3:0] m,
                      input logic bit_in);
    pat_load    = 1'b1;
    pat_in      = p;
    pat_mask_in = m;
    din_valid   = 1'b1;
    din         = bit_in;
    tick(name, 1'b0, 8'd0);
    pat_load    = 1'b0;
    din_valid   = 1'b0;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    chk1          = 1'b1;
    chk2          = 1'b0;
    rst_n         = 1'b0;
    din_valid     = 1'b0;
    din           = 1'b0;
    overlap       = 1'b1;
    pat_load      = 1'b0;
    pat_load2     = 1'b0;
    pat_in        = 4'b0000;
    pat_mask_in   = 4'b0000;
    pat_mask_zero = 4'b0000;

    do_reset("reset_state");
    overlap = 1'b1;
    run_vec("overlap", "1101101", "0001001", "0001112");

    do_reset("reset2");
    overlap = 1'b0;
    run_vec("nonoverlap", "1101101", "0001000", "0001111");

    do_reset("reset3");
    overlap = 1'b1;
    run_vec("gaps", "1...1...0...1.", "00000000000010", "00000000000011");

    do_reset("reset4");
    run_vec("pre_reset", "110", "000", "000");
    do_reset("mid_reset");
    run_vec("post_reset", "11101", "00001", "00001");

    load("load_clears", 4'b0011, 4'b0000, 1'b1);
    run_vec("new_pat", "0011", "0001", "0001");
    run_vec("old_pat", "1101", "0000", "1111");

`ifdef SEQ_DETECT_MASK_EN
    load("mask_load", 4'b1101, 4'b0100, 1'b0);
    run_vec("masked", "1001", "0001", "0001");
`endif

    do_reset("reset6");
    chk1    = 1'b0;
    chk2    = 1'b1;
    overlap = 1'b1;
    run_vec("saturate", "1101101101101101", "0001001001001001", "0001112223333333");
    chk2    = 1'b0;

    for (int i = 0; i < 10 && (exp_q.size() > 0 || exp2_q.size() > 0); i++)
      @(posedge clk);
    if (exp_q.size() > 0 || exp2_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, expected 0",
               exp_q.size() + exp2_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
